stopwatch_display_scan: RTL



---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/stopwatch_display_scan_seg_encode.sv | 14 +
 rtl/stopwatch_display_scan.sv | 111 +++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared display constants: segment patterns, dp position and the digit-frame payload.
package stopwatch_pkg;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned SEG_W  = 15;
   localparam int unsigned DP_BIT = 14;

   localparam logic [SEG_W-1:0] SEG_BLANK = 15'h7FFF;
   localparam logic [SEG_W-1:0] SEG_DASH  = 15'h7F3F;

   // Active-low patterns; bits 0..5 = a..f, 6/7 = middle halves, 14 = dp
   localparam logic [SEG_W-1:0] BCD_SEG [0:9] = '{
      15'h7FC0, 15'h7FF9, 15'h7F24, 15'h7F30, 15'h7F19,
      15'h7F12, 15'h7F02, 15'h7FF8, 15'h7F00, 15'h7F10
   };

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t       d3;
      bcd_t       d2;
      bcd_t       d1;
      bcd_t       d0;
      logic [3:0] blink_mask;
      logic       blank_lz;
      logic       dp_en;
   } frame_t;

endpackage

// File: rtl/stopwatch_display_scan_seg_encode.sv
// Nibble to 15-segment pattern; 10..15 render as a dash.
module seg_encode
   import stopwatch_pkg::*;
(
   input  logic [3:0]       digit,
   output logic [SEG_W-1:0] seg_c
);

   always_comb begin
      seg_c = SEG_DASH;
      if (digit < 4'd10) seg_c = BCD_SEG[digit];
   end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Multiplexed 4-digit scan with frame-coherent latching, leading-zero blanking and blink.
module stopwatch_display_scan
   import stopwatch_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 25000,
   parameter int unsigned BLINK_FRAMES = 250
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       in0,
   input  logic [3:0]       in1,
   input  logic [3:0]       in2,
   input  logic [3:0]       in3,
   input  logic [3:0]       blink_mask,
   input  logic             blank_lz,
   input  logic             dp_en,
   output logic [SEG_W-1:0] display,
   output logic [3:0]       wh_light
);

   localparam int unsigned PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(SCAN_DIV - 1);
   localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(BLINK_FRAMES - 1);

   logic [PCNT_W-1:0] pcnt;
   logic [1:0]        idx;
   logic [FCNT_W-1:0] fcnt;
   logic              bph;
   frame_t            shadow;

   logic              tick;
   logic              frame_wrap;
   logic [1:0]        idx_nxt;
   logic [FCNT_W-1:0] fcnt_nxt;
   logic              bph_nxt;
   frame_t            frame_nxt;
   bcd_t              sel_digit;
   logic [SEG_W-1:0]  sel_seg;
   logic              lz3, lz2, lz1;
   logic              lz_blank;
   logic              blink_blank;
   logic [SEG_W-1:0]  display_nxt;
   logic [3:0]        wh_light_nxt;

   // Sequencing: the frame boundary latches inputs and advances the blink counter
   always_comb begin
      tick       = (pcnt == PCNT_MAX);
      frame_wrap = tick && (idx == 2'd3);
      idx_nxt    = idx + 2'd1;
      frame_nxt  = shadow;
      fcnt_nxt   = fcnt;
      bph_nxt    = bph;
      if (frame_wrap) begin
         frame_nxt = '{d3: in3, d2: in2, d1: in1, d0: in0, blink_mask: blink_mask,
                       blank_lz: blank_lz, dp_en: dp_en};
         if (fcnt == FCNT_MAX) begin
            fcnt_nxt = '0;
            bph_nxt  = ~bph;
         end else begin
            fcnt_nxt = fcnt + FCNT_W'(1);
         end
      end
   end

   // Output pair for the digit about to be selected, using post-latch frame values
   always_comb begin
      lz3 = frame_nxt.blank_lz && (frame_nxt.d3 == 4'd0);
      lz2 = lz3 && (frame_nxt.d2 == 4'd0);
      lz1 = lz2 && (frame_nxt.d1 == 4'd0);
      unique case (idx_nxt)
         2'd0:    begin sel_digit = frame_nxt.d0; lz_blank = 1'b0; end
         2'd1:    begin sel_digit = frame_nxt.d1; lz_blank = lz1;  end
         2'd2:    begin sel_digit = frame_nxt.d2; lz_blank = lz2;  end
         default: begin sel_digit = frame_nxt.d3; lz_blank = lz3;  end
      endcase
      blink_blank = frame_nxt.blink_mask[idx_nxt] && bph_nxt;
      display_nxt = (blink_blank || lz_blank) ? SEG_BLANK : sel_seg;
      // Colon survives leading-zero blanking but not blink
      if ((idx_nxt == 2'd2) && frame_nxt.dp_en && !blink_blank) display_nxt[DP_BIT] = 1'b0;
      wh_light_nxt = ~(4'b0001 << idx_nxt);
   end

   seg_encode u_seg_encode (
      .digit (sel_digit),
      .seg_c (sel_seg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt     <= '0;
         idx      <= 2'd3;
         fcnt     <= '0;
         bph      <= 1'b0;
         shadow   <= '0;
         display  <= SEG_BLANK;
         wh_light <= 4'b1111;
      end else begin
         pcnt <= tick ? '0 : pcnt + PCNT_W'(1);
         if (tick) begin
            idx      <= idx_nxt;
            shadow   <= frame_nxt;
            fcnt     <= fcnt_nxt;
            bph      <= bph_nxt;
            display  <= display_nxt;
            wh_light <= wh_light_nxt;
         end
      end
   end

endmodule
